multicycle_controller: RTL

Sequencing controller for the multicycle RV32I core. It steps the shared datapath (single memory port, one ALU, IR/PC/register-file write enables) through fetch, decode, execute, memory and writeback states for lw, sw, R-type, I-type ALU, beq and jal. It stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions. It sits between the instruction register and the datapath, replacing the single-cycle main decoder in the multicycle build.

---
 rtl/riscv_ctrl_pkg.sv | 56 +++++
 rtl/mc_instr_decoder.sv | 44 ++++
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared states, opcodes and datapath select encodings for the multicycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
    } op_class_t;

endpackage

// File: rtl/mc_instr_decoder.sv
// rtl/mc_instr_decoder.sv - combinational opcode decode into immediate format and one-hot opcode class
module mc_instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src,
    output op_class_t  op_class
);

    always_comb begin
        imm_src  = IMM_I;
        op_class = '0;
        case (op)
            OP_LOAD: begin
                imm_src        = IMM_I;
                op_class.load  = 1'b1;
            end
            OP_STORE: begin
                imm_src        = IMM_S;
                op_class.store = 1'b1;
            end
            OP_RTYPE: begin
                op_class.rtype = 1'b1;
            end
            OP_ITYPE: begin
                imm_src        = IMM_I;
                op_class.itype = 1'b1;
            end
            OP_BRANCH: begin
                imm_src         = IMM_B;
                op_class.branch = 1'b1;
            end
            OP_JAL: begin
                imm_src      = IMM_J;
                op_class.jal = 1'b1;
            end
            default: begin
                imm_src  = IMM_I;
                op_class = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I sequencing FSM with retire counter and sticky illegal flag
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_src,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t w_class;
    logic [31:0] r_retired;
    logic        r_illegal;

    mc_instr_decoder u_decoder (
        .op       (op),
        .imm_src  (imm_src),
        .op_class (w_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // op is only consulted in DECODE and MEMADR; elsewhere it may be stale
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_class.load || w_class.store) w_next_state = S_MEMADR;
                else if (w_class.rtype)            w_next_state = S_EXECUTER;
                else if (w_class.itype)            w_next_state = S_EXECUTEI;
                else if (w_class.branch)           w_next_state = S_BEQ;
                else if (w_class.jal)              w_next_state = S_JAL;
                else                               w_next_state = S_ILLEGAL;
            end
            S_MEMADR:   w_next_state = w_class.load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        // Reset already forces FETCH; only the strobes need explicit masking
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_ILLEGAL) begin
            r_illegal <= 1'b1;
        end
    end

    assign retired = r_retired;
    assign illegal = r_illegal;

endmodule
